// File: rtl/irrigation_mode_encoder.sv
// Irrigation control FSM: debounces the raw humidity, tank and enable inputs and drives the
// 2-bit display mode code, the sprinkler/drip valves and the minimum-hold indicator.
module irrigation_mode_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_ON_CYCLES   = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] humidity,
  input  logic       tank_ok,
  input  logic       enable,
  output logic       bit0,
  output logic       bit1,
  output logic       sprinkler_on,
  output logic       drip_on,
  output logic       hold_active
);

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StSprinkler = 2'b01,
    StDrip      = 2'b10,
    StBlocked   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DebCnt   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(MIN_ON_CYCLES - 1);

  logic [1:0]       hum_raw_q, hum_filt_q, hum_filt_d;
  logic             tank_raw_q, tank_filt_q, tank_filt_d;
  logic             en_raw_q, en_filt_q, en_filt_d;
  logic [CNT_W-1:0] hum_cnt_q, hum_cnt_d, hum_run;
  logic [CNT_W-1:0] tank_cnt_q, tank_cnt_d, tank_run;
  logic [CNT_W-1:0] en_cnt_q, en_cnt_d, en_run;
  logic [CNT_W-1:0] hold_q, hold_d;
  state_e           state_q, state_d, target;

  // Length of the current run of identical raw samples that differ from the filtered value,
  // including this edge; a raw change restarts the run at this sample.
  function automatic logic [CNT_W-1:0] run_len(input logic differ, input logic same,
                                               input logic [CNT_W-1:0] cnt);
    if (!differ) return '0;
    else if (same) return cnt + 1'b1;
    else return CNT_W'(1);
  endfunction

  always_comb begin
    hum_run     = run_len(humidity != hum_filt_q, humidity == hum_raw_q, hum_cnt_q);
    hum_filt_d  = (hum_run == DebCnt) ? humidity : hum_filt_q;
    hum_cnt_d   = (hum_run == DebCnt) ? '0 : hum_run;
    tank_run    = run_len(tank_ok != tank_filt_q, tank_ok == tank_raw_q, tank_cnt_q);
    tank_filt_d = (tank_run == DebCnt) ? tank_ok : tank_filt_q;
    tank_cnt_d  = (tank_run == DebCnt) ? '0 : tank_run;
    en_run      = run_len(enable != en_filt_q, enable == en_raw_q, en_cnt_q);
    en_filt_d   = (en_run == DebCnt) ? enable : en_filt_q;
    en_cnt_d    = (en_run == DebCnt) ? '0 : en_run;
  end

  always_comb begin
    if (!en_filt_q || !tank_filt_q) target = StBlocked;
    else if (hum_filt_q == 2'b00)   target = StIdle;
    else if (hum_filt_q == 2'b01)   target = StDrip;
    else                            target = StSprinkler;

    state_d = state_q;
    case (state_q)
      StIdle, StBlocked: state_d = target;
      default: begin
        // Safety exit ignores the hold; any other change waits for it to expire.
        if (target == StBlocked) state_d = StBlocked;
        else if (target != state_q && hold_q == '0) state_d = target;
      end
    endcase

    if (state_d == StSprinkler || state_d == StDrip) begin
      if (state_d != state_q) hold_d = HoldLoad;
      else if (hold_q != '0)  hold_d = hold_q - 1'b1;
      else                    hold_d = '0;
    end else begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hum_raw_q    <= '0;
      hum_filt_q   <= '0;
      hum_cnt_q    <= '0;
      tank_raw_q   <= 1'b0;
      tank_filt_q  <= 1'b0;
      tank_cnt_q   <= '0;
      en_raw_q     <= 1'b0;
      en_filt_q    <= 1'b0;
      en_cnt_q     <= '0;
      state_q      <= StIdle;
      hold_q       <= '0;
      bit0         <= 1'b0;
      bit1         <= 1'b0;
      sprinkler_on <= 1'b0;
      drip_on      <= 1'b0;
      hold_active  <= 1'b0;
    end else begin
      hum_raw_q    <= humidity;
      hum_filt_q   <= hum_filt_d;
      hum_cnt_q    <= hum_cnt_d;
      tank_raw_q   <= tank_ok;
      tank_filt_q  <= tank_filt_d;
      tank_cnt_q   <= tank_cnt_d;
      en_raw_q     <= enable;
      en_filt_q    <= en_filt_d;
      en_cnt_q     <= en_cnt_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      bit0         <= state_d[0];
      bit1         <= state_d[1];
      sprinkler_on <= (state_d == StSprinkler);
      drip_on      <= (state_d == StDrip);
      hold_active  <= (hold_d != '0);
    end
  end

endmodule

// File: tb/tb_irrigation_mode_encoder.sv
// Directed scenarios followed by randomized input sequences, all checked every edge against
// a sample-history reference model of the irrigation controller.
module tb_irrigation_mode_encoder;
  localparam int D = 4;
  localparam int M = 16;
  localparam int IDLE = 0, SPR = 1, DRIP = 2, BLK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] humidity = 2'b00;
  logic       tank_ok = 1'b0;
  logic       enable = 1'b0;
  logic       bit0, bit1, sprinkler_on, drip_on, hold_active;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] hist[$];
  logic [1:0] f_hum;
  logic       f_tank, f_en;
  int         m_state = IDLE;
  int         m_hold = 0;

  irrigation_mode_encoder #(
    .DEBOUNCE_CYCLES(D),
    .MIN_ON_CYCLES  (M),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .humidity    (humidity),
    .tank_ok     (tank_ok),
    .enable      (enable),
    .bit0        (bit0),
    .bit1        (bit1),
    .sprinkler_on(sprinkler_on),
    .drip_on     (drip_on),
    .hold_active (hold_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A filtered input follows the raw input once the last D samples since reset agree and
  // differ from it. The FSM acts on the filtered values held before this edge.
  task automatic model_edge();
    logic [3:0] s;
    int tgt, nxt;
    bit h_same, t_same, e_same;
    s = {humidity, tank_ok, enable};
    if (rst) begin
      hist.delete();
      f_hum = 2'b00; f_tank = 1'b0; f_en = 1'b0;
      m_state = IDLE; m_hold = 0;
      return;
    end
    if (!f_en || !f_tank) tgt = BLK;
    else if (f_hum == 2'b00) tgt = IDLE;
    else if (f_hum == 2'b01) tgt = DRIP;
    else tgt = SPR;
    if (m_state == IDLE || m_state == BLK) nxt = tgt;
    else if (tgt == BLK) nxt = BLK;
    else if (tgt != m_state && m_hold == 0) nxt = tgt;
    else nxt = m_state;
    if (nxt == SPR || nxt == DRIP) m_hold = (nxt != m_state) ? M - 1 : (m_hold > 0 ? m_hold - 1 : 0);
    else m_hold = 0;
    m_state = nxt;

    hist.push_back(s);
    if (hist.size() > D) void'(hist.pop_front());
    if (hist.size() == D) begin
      h_same = 1; t_same = 1; e_same = 1;
      foreach (hist[i]) begin
        if (hist[i][3:2] != s[3:2]) h_same = 0;
        if (hist[i][1] != s[1]) t_same = 0;
        if (hist[i][0] != s[0]) e_same = 0;
      end
      if (h_same) f_hum = s[3:2];
      if (t_same) f_tank = s[1];
      if (e_same) f_en = s[0];
    end
  endtask

  task automatic step();
    logic [7:0] exp;
    @(posedge clk);
    model_edge();
    #1;
    exp = {3'b000, 2'(m_state), m_state == SPR, m_state == DRIP, m_hold != 0};
    chk("model", {3'b000, bit1, bit0, sprinkler_on, drip_on, hold_active}, exp);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  function automatic logic [7:0] outs();
    return {3'b000, bit1, bit0, sprinkler_on, drip_on, hold_active};
  endfunction

  initial begin
    rst = 1'b1;
    run(2);
    chk("reset_outs", outs(), 8'h00);

    // Scenario 1: enabled with water and wet soil after reset.
    enable = 1'b1; tank_ok = 1'b1; humidity = 2'b00; rst = 1'b0;
    step();
    chk("t1_blocked_first", outs(), 8'h18);
    run(D - 1);
    chk("t1_still_blocked", outs(), 8'h18);
    step();
    chk("t1_idle", outs(), 8'h00);

    // Scenario 2/3: dry -> sprinkler, then moderate during the hold.
    humidity = 2'b10;
    run(D);
    chk("t2_latency", outs(), 8'h00);
    step();
    chk("t2_sprinkler", outs(), 8'h0D);
    run(4);
    humidity = 2'b01;
    run(11);
    chk("t3_hold_expired", outs(), 8'h0C);
    step();
    chk("t3_drip", outs(), 8'h13);

    // Scenario 4: enable drop preempts the hold.
    enable = 1'b0;
    run(D);
    chk("t4_before", outs(), 8'h13);
    step();
    chk("t4_blocked", outs(), 8'h18);

    // Scenario 5: glitch rejection and minimum pulse.
    enable = 1'b1; humidity = 2'b00;
    run(D + 1);
    chk("t5_idle", outs(), 8'h00);
    humidity = 2'b10;
    run(D - 1);
    humidity = 2'b00;
    run(6);
    chk("t5_glitch_rejected", outs(), 8'h00);
    humidity = 2'b10;
    run(D);
    humidity = 2'b00;
    step();
    chk("t5_pulse_sprinkler", outs(), 8'h0D);

    // Scenario 6: reset mid-sprinkler.
    run(3);
    rst = 1'b1;
    step();
    chk("t6_reset", outs(), 8'h00);
    rst = 1'b0;
    step();
    chk("t6_blocked", outs(), 8'h18);
    run(D - 1);
    chk("t6_still_blocked", outs(), 8'h18);
    step();
    chk("t6_idle", outs(), 8'h00);

    // Randomized segments of held inputs, including short glitches and occasional reset.
    repeat (250) begin
      humidity = 2'($urandom_range(0, 3));
      tank_ok  = ($urandom_range(0, 9) != 0);
      enable   = ($urandom_range(0, 9) != 0);
      rst      = ($urandom_range(0, 39) == 0);
      run($urandom_range(1, 9));
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
